vga_timing_gen: RTL

- Produces the scan-side half of the pixel interface used by every sprite and background renderer: the pixel clock, scan coordinates, the display-enable flag and the sync pulses.
- Renderers read their ROMs on vga_clk falling and register pixels on vga_clk rising. This block therefore changes all scan outputs on the Clk edge where vga_clk falls.
- Sits at top level between the 50 MHz system clock and the VGA DAC/color mapper. Default timing is 640x480 at 60 Hz.

---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/vga_timing_gen_if.sv | 32 +++
 rtl/vga_axis_counter.sv | 76 +++++++
 rtl/vga_timing_gen.sv | 128 ++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared timing constants for the VGA scan generator.
// Default timing is 640x480 at 60 Hz from a 50 MHz clock (CLK_DIV = 2).
package vga_timing_pkg;

  // Width of every scan coordinate; each axis total must fit in it.
  localparam int COORD_W = 10;

  localparam int DEF_CLK_DIV   = 2;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;

  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Sync pulse covers [start, end) on each axis.
  localparam int H_SYNC_START = DEF_H_VISIBLE + DEF_H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;
  localparam int V_SYNC_START = DEF_V_VISIBLE + DEF_V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: scan-side pixel interface shared by the timing
// generator (master) and the renderers / DAC mapper (slave).
// frame_count exists only when VGA_FRAME_COUNT_EN is defined.
interface vga_timing_gen_if;

  logic                               vga_clk;
  logic [vga_timing_pkg::COORD_W-1:0] DrawX;
  logic [vga_timing_pkg::COORD_W-1:0] DrawY;
  logic                               blank;
  logic                               hs;
  logic                               vs;
  logic                               frame_start;
  logic                               pixel_tick;
`ifdef VGA_FRAME_COUNT_EN
  logic [7:0]                         frame_count;
`endif

  modport master (
    output vga_clk, DrawX, DrawY, blank, hs, vs, frame_start, pixel_tick
`ifdef VGA_FRAME_COUNT_EN
    , output frame_count
`endif
  );

  modport slave (
    input vga_clk, DrawX, DrawY, blank, hs, vs, frame_start, pixel_tick
`ifdef VGA_FRAME_COUNT_EN
    , input frame_count
`endif
  );

endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one scan axis. Wrap counter with enable and carry,
// plus registered position, active and sync decode taken from the new count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VISIBLE = DEF_H_VISIBLE,
  parameter int FP      = DEF_H_FP,
  parameter int SYNC    = DEF_H_SYNC,
  parameter int BP      = DEF_H_BP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  output logic [COORD_W-1:0] o_pos,
  output logic               o_active,
  output logic               o_sync_n,
  output logic               o_carry
);

  localparam int TOTAL = VISIBLE + FP + SYNC + BP;

  if (TOTAL > (1 << COORD_W) || TOTAL < 1) begin : g_bad_total
    $error("vga_axis_counter: axis total %0d does not fit in %0d bits", TOTAL, COORD_W);
  end

  // Bounds are one bit wider so a sync end equal to 2**COORD_W still compares.
  localparam logic [COORD_W-1:0] LAST       = COORD_W'(TOTAL - 1);
  localparam logic [COORD_W:0]   VIS_END    = (COORD_W+1)'(VISIBLE);
  localparam logic [COORD_W:0]   SYNC_START = (COORD_W+1)'(VISIBLE + FP);
  localparam logic [COORD_W:0]   SYNC_END   = (COORD_W+1)'(VISIBLE + FP + SYNC);

  logic [COORD_W-1:0] r_count;
  logic [COORD_W-1:0] r_pos;
  logic               r_active;
  logic               r_sync_n;
  logic               w_at_last;
  logic [COORD_W-1:0] w_next;
  logic [COORD_W:0]   w_next_ext;

  // Next count: wrap at the last position, otherwise increment.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_at_last  = 1'b0;
    w_next     = r_count + 1'b1;
    if (r_count == LAST) begin
      w_at_last = 1'b1;
      w_next    = '0;
    end
    w_next_ext = {1'b0, w_next};
  end

  // Count and decode registers; all decode is from the new count so the
  // position and flags change together on the same edge.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      r_count  <= LAST;
      r_pos    <= '0;
      r_active <= 1'b0;
      r_sync_n <= 1'b1;
    end else if (i_en) begin
      r_count  <= w_next;
      r_pos    <= w_next;
      r_active <= (w_next_ext < VIS_END);
      r_sync_n <= !((w_next_ext >= SYNC_START) && (w_next_ext < SYNC_END));
    end
  end

  assign o_pos    = r_pos;
  assign o_active = r_active;
  assign o_sync_n = r_sync_n;
  assign o_carry  = i_en & w_at_last;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel clock divider and scan generator for the VGA path.
// All scan outputs change on the Clk edge where vga_clk falls, leaving
// CLK_DIV/2 Clk cycles of setup before renderers sample on vga_clk rising.
// Optional macro VGA_FRAME_COUNT_EN adds an 8-bit frame counter output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP
) (
  input  logic              Clk,
  input  logic              Reset,
  vga_timing_gen_if.master  vga
);

  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV=%0d must be even and at least 2", CLK_DIV);
  end

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  logic [DIV_W-1:0]   r_div_cnt;
  logic               r_vga_clk;
  logic               r_pixel_tick;
  logic               r_frame_start;
  logic               w_tick;
  logic [DIV_W-1:0]   w_div_next;
  logic               w_h_carry;
  logic               w_frame_wrap;
  logic               w_h_active;
  logic               w_v_active;
  logic               w_hs_n;
  logic               w_vs_n;
  logic [COORD_W-1:0] w_draw_x;
  logic [COORD_W-1:0] w_draw_y;

  // A tick is the edge on which the divider wraps to 0.
  assign w_tick     = (r_div_cnt == DIV_LAST);
  assign w_div_next = w_tick ? '0 : r_div_cnt + 1'b1;

  // Divider and pixel clock: vga_clk drops on the tick edge and rises
  // CLK_DIV/2 edges later, giving a 50% duty cycle.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_div_cnt <= '0;
      r_vga_clk <= 1'b0;
    end else begin
      r_div_cnt <= w_div_next;
      r_vga_clk <= (w_div_next >= DIV_HALF);
    end
  end

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FP      (H_FP),
    .SYNC    (H_SYNC),
    .BP      (H_BP)
  ) u_h_axis (
    .clk      (Clk),
    .rst      (Reset),
    .i_en     (w_tick),
    .o_pos    (w_draw_x),
    .o_active (w_h_active),
    .o_sync_n (w_hs_n),
    .o_carry  (w_h_carry)
  );

  // The vertical carry only fires when both axes wrap: the new position is (0,0).
  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FP      (V_FP),
    .SYNC    (V_SYNC),
    .BP      (V_BP)
  ) u_v_axis (
    .clk      (Clk),
    .rst      (Reset),
    .i_en     (w_h_carry),
    .o_pos    (w_draw_y),
    .o_active (w_v_active),
    .o_sync_n (w_vs_n),
    .o_carry  (w_frame_wrap)
  );

  // Single-cycle strobes aligned with the scan update.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pixel_tick  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_pixel_tick  <= w_tick;
      r_frame_start <= w_frame_wrap;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] r_frame_count;

  // Animation frame counter, advances with every frame_start and wraps.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_frame_count <= '0;
    end else if (w_frame_wrap) begin
      r_frame_count <= r_frame_count + 8'd1;
    end
  end

  assign vga.frame_count = r_frame_count;
`endif

  assign vga.vga_clk     = r_vga_clk;
  assign vga.DrawX       = w_draw_x;
  assign vga.DrawY       = w_draw_y;
  assign vga.blank       = w_h_active & w_v_active;
  assign vga.hs          = w_hs_n;
  assign vga.vs          = w_vs_n;
  assign vga.frame_start = r_frame_start;
  assign vga.pixel_tick  = r_pixel_tick;

endmodule
